// File: rtl/branch_resolve_unit_if.sv
// Dispatch / branch-RS CDB / ROB-head bundle for the branch resolve unit.
// The master side (dispatch, RS, ROB) drives requests; the slave side is the unit.
interface branch_resolve_unit_if #(
    parameter int ROB_DEPTH = 3
);
    logic                 alloc_valid;
    logic [ROB_DEPTH-1:0] alloc_rob;
    logic [31:0]          alloc_pred_pc;
    logic                 cdb_branch_rs_valid;
    logic [ROB_DEPTH-1:0] cdb_branch_rs_rob;
    logic                 cdb_branch_take;
    logic [31:0]          cdb_branch_target_pc;
    logic                 commit_valid;
    logic [ROB_DEPTH-1:0] commit_rob;
    logic                 commit_branch_ok;
    logic                 move_flush;
    logic [31:0]          flush_pc;
    logic                 busy;
    logic [31:0]          br_count;
    logic [31:0]          mispred_count;

    modport master (
        output alloc_valid, alloc_rob, alloc_pred_pc,
        output cdb_branch_rs_valid, cdb_branch_rs_rob, cdb_branch_take, cdb_branch_target_pc,
        output commit_valid, commit_rob,
        input  commit_branch_ok, move_flush, flush_pc, busy, br_count, mispred_count
    );

    modport slave (
        input  alloc_valid, alloc_rob, alloc_pred_pc,
        input  cdb_branch_rs_valid, cdb_branch_rs_rob, cdb_branch_take, cdb_branch_target_pc,
        input  commit_valid, commit_rob,
        output commit_branch_ok, move_flush, flush_pc, busy, br_count, mispred_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: records branch predictions at dispatch, resolved next-PCs
// from the branch RS CDB, and at commit raises a one-cycle flush with the
// redirect PC when the resolved next-PC differs from what fetch followed.
module branch_resolve_unit #(
    parameter int ROB_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int N = 2 ** ROB_DEPTH;

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   mis_q, mis_d;
    logic [31:0]    flush_pc_q, flush_pc_d;
    logic [31:0]    br_count_q, br_count_d;
    logic [31:0]    mispred_count_q, mispred_count_d;

    // Per-entry payload; only meaningful while the entry is pending, so no reset.
    logic [31:0]    pred_pc_q [N];
    logic [31:0]    act_pc_q [N];
    logic [N-1:0]   take_q;

    logic           idle;
    logic           alloc_en;
    logic           cdb_en;
    logic           cdb_mis;
    logic           commit_ok;
    logic           unused_take;

    // The direction bit is kept for debug visibility; the next-PC compare
    // already captures every mispredict, so nothing downstream consumes it.
    assign unused_take = ^take_q;

    // Event qualification: alloc and CDB only act in IDLE, alloc wins a same-tag
    // collision, and commit sees only results registered in earlier cycles.
    always_comb begin
        idle      = (state_q == IDLE);
        alloc_en  = idle && bus.alloc_valid;
        cdb_en    = idle && bus.cdb_branch_rs_valid
                    && pend_q[bus.cdb_branch_rs_rob] && !res_q[bus.cdb_branch_rs_rob]
                    && !(alloc_en && (bus.alloc_rob == bus.cdb_branch_rs_rob));
        cdb_mis   = (bus.cdb_branch_target_pc != pred_pc_q[bus.cdb_branch_rs_rob]);
        commit_ok = idle && bus.commit_valid
                    && pend_q[bus.commit_rob] && res_q[bus.commit_rob];
    end

    // Next state of the per-entry flags and the commit counters.
    always_comb begin
        pend_d          = pend_q;
        res_d           = res_q;
        mis_d           = mis_q;
        flush_pc_d      = flush_pc_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (commit_ok) begin
            pend_d[bus.commit_rob] = 1'b0;
            res_d[bus.commit_rob]  = 1'b0;
            br_count_d             = br_count_q + 32'd1;
            if (mis_q[bus.commit_rob]) begin
                mispred_count_d = mispred_count_q + 32'd1;
                flush_pc_d      = act_pc_q[bus.commit_rob];
            end
        end
        if (alloc_en) begin
            pend_d[bus.alloc_rob] = 1'b1;
            res_d[bus.alloc_rob]  = 1'b0;
            mis_d[bus.alloc_rob]  = 1'b0;
        end
        if (cdb_en) begin
            res_d[bus.cdb_branch_rs_rob] = 1'b1;
            mis_d[bus.cdb_branch_rs_rob] = cdb_mis;
        end
        // Everything in flight is on the wrong path once the flush fires.
        if (state_q == FLUSH) begin
            pend_d = '0;
            res_d  = '0;
            mis_d  = '0;
        end
    end

    // FSM next state: a mispredicted commit triggers FLUSH then RECOVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_ok && mis_q[bus.commit_rob]) state_d = FLUSH;
            FLUSH:   state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: flush pulse and busy are decoded from the registered state.
    always_comb begin
        bus.move_flush       = (state_q == FLUSH);
        bus.busy             = (state_q != IDLE);
        bus.commit_branch_ok = commit_ok;
        bus.flush_pc         = flush_pc_q;
        bus.br_count         = br_count_q;
        bus.mispred_count    = mispred_count_q;
    end

    // State register and control flags, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            pend_q          <= '0;
            res_q           <= '0;
            mis_q           <= '0;
            flush_pc_q      <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            res_q           <= res_d;
            mis_q           <= mis_d;
            flush_pc_q      <= flush_pc_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // Payload capture at allocation and at resolution.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pred_pc_q[bus.alloc_rob] <= bus.alloc_pred_pc;
        end
        if (cdb_en) begin
            act_pc_q[bus.cdb_branch_rs_rob] <= bus.cdb_branch_target_pc;
            take_q[bus.cdb_branch_rs_rob]   <= bus.cdb_branch_take;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, reset and
// wrap sequences, then randomized traffic checked against a behavioural model.
module tb_branch_resolve_unit;
    localparam int RD = 3;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit_if #(.ROB_DEPTH(RD)) bus ();

    branch_resolve_unit #(.ROB_DEPTH(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: entry flags/payload plus a count of remaining busy cycles.
    logic        m_pend [N];
    logic        m_res  [N];
    logic        m_mis  [N];
    logic [31:0] m_pred [N];
    logic [31:0] m_act  [N];
    int          m_busy_left;
    logic [31:0] m_fpc;
    logic [31:0] m_br;
    logic [31:0] m_mp;

    typedef struct {
        logic        av; logic [2:0] ar; logic [31:0] ap;
        logic        cv; logic [2:0] cr; logic ct; logic [31:0] cp;
        logic        mv; logic [2:0] mr;
        logic        exp_ok; logic exp_flush; logic exp_busy; logic [31:0] exp_fpc;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_res[i] = 1'b0; m_mis[i] = 1'b0;
        end
        m_busy_left = 0; m_fpc = 32'd0; m_br = 32'd0; m_mp = 32'd0;
    endtask

    task automatic drive(input logic av, input logic [2:0] ar, input logic [31:0] ap,
                         input logic cv, input logic [2:0] cr, input logic ct, input logic [31:0] cp,
                         input logic mv, input logic [2:0] mr);
        bus.alloc_valid = av; bus.alloc_rob = ar; bus.alloc_pred_pc = ap;
        bus.cdb_branch_rs_valid = cv; bus.cdb_branch_rs_rob = cr;
        bus.cdb_branch_take = ct; bus.cdb_branch_target_pc = cp;
        bus.commit_valid = mv; bus.commit_rob = mr;
    endtask

    task automatic drive_idle();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 3'd0);
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle_check();
        logic exp_ok;
        #1;
        exp_ok = bus.commit_valid && (m_busy_left == 0)
                 && m_pend[bus.commit_rob] && m_res[bus.commit_rob];
        chk("commit_branch_ok", 32'(bus.commit_branch_ok), 32'(exp_ok));
        chk("busy", 32'(bus.busy), 32'(m_busy_left != 0));
        chk("move_flush", 32'(bus.move_flush), 32'(m_busy_left == 2));
        if (m_busy_left == 2) chk("flush_pc", bus.flush_pc, m_fpc);
        chk("br_count", bus.br_count, m_br);
        chk("mispred_count", bus.mispred_count, m_mp);
    endtask

    // Apply this cycle's inputs to the model, then cross the clock edge.
    task automatic tick();
        logic ok, hit, mis;
        if (m_busy_left == 2) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0; m_res[i] = 1'b0; m_mis[i] = 1'b0;
            end
            m_busy_left = 1;
        end else if (m_busy_left == 1) begin
            m_busy_left = 0;
        end else begin
            ok  = bus.commit_valid && m_pend[bus.commit_rob] && m_res[bus.commit_rob];
            hit = bus.cdb_branch_rs_valid && m_pend[bus.cdb_branch_rs_rob]
                  && !m_res[bus.cdb_branch_rs_rob]
                  && !(bus.alloc_valid && bus.alloc_rob == bus.cdb_branch_rs_rob);
            mis = bus.cdb_branch_target_pc != m_pred[bus.cdb_branch_rs_rob];
            if (ok) begin
                m_pend[bus.commit_rob] = 1'b0;
                m_res[bus.commit_rob]  = 1'b0;
                m_br = m_br + 32'd1;
                if (m_mis[bus.commit_rob]) begin
                    m_mp = m_mp + 32'd1;
                    m_fpc = m_act[bus.commit_rob];
                    m_busy_left = 2;
                end
            end
            if (bus.alloc_valid) begin
                m_pend[bus.alloc_rob] = 1'b1;
                m_res[bus.alloc_rob]  = 1'b0;
                m_mis[bus.alloc_rob]  = 1'b0;
                m_pred[bus.alloc_rob] = bus.alloc_pred_pc;
            end
            if (hit) begin
                m_res[bus.cdb_branch_rs_rob] = 1'b1;
                m_mis[bus.cdb_branch_rs_rob] = mis;
                m_act[bus.cdb_branch_rs_rob] = bus.cdb_branch_target_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    function automatic vec_t mk(input logic av, input logic [2:0] ar, input logic [31:0] ap,
                                input logic cv, input logic [2:0] cr, input logic ct,
                                input logic [31:0] cp, input logic mv, input logic [2:0] mr,
                                input logic eo, input logic ef, input logic eb,
                                input logic [31:0] efp);
        vec_t v;
        v.av = av; v.ar = ar; v.ap = ap; v.cv = cv; v.cr = cr; v.ct = ct; v.cp = cp;
        v.mv = mv; v.mr = mr; v.exp_ok = eo; v.exp_flush = ef; v.exp_busy = eb; v.exp_fpc = efp;
        return v;
    endfunction

    initial begin
        //            alloc                   cdb                             commit    ok fl bz fpc
        tbl[0]  = mk(1, 3'd2, 32'h1000_0008, 0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 3'd0, 32'h0,         1, 3'd2, 0, 32'h1000_0008,   0, 3'd0, 0, 0, 0, 32'h0);
        tbl[2]  = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 0, 32'h0);
        tbl[3]  = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd2, 1, 0, 0, 32'h0);
        tbl[4]  = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 3'd5, 32'h1000_0014, 0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 0, 32'h0);
        tbl[6]  = mk(0, 3'd0, 32'h0,         1, 3'd5, 1, 32'h1000_0100,   0, 3'd0, 0, 0, 0, 32'h0);
        tbl[7]  = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd5, 1, 0, 0, 32'h0);
        tbl[8]  = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 1, 1, 32'h1000_0100);
        tbl[9]  = mk(1, 3'd3, 32'h20,        0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 1, 32'h0);
        tbl[10] = mk(0, 3'd0, 32'h0,         1, 3'd3, 0, 32'h24,          0, 3'd0, 0, 0, 0, 32'h0);
        tbl[11] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd3, 0, 0, 0, 32'h0);
        tbl[12] = mk(1, 3'd1, 32'h40,        0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 0, 32'h0);
        tbl[13] = mk(0, 3'd0, 32'h0,         1, 3'd1, 0, 32'h40,          1, 3'd1, 0, 0, 0, 32'h0);
        tbl[14] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd1, 1, 0, 0, 32'h0);
        tbl[15] = mk(0, 3'd0, 32'h0,         1, 3'd7, 0, 32'h50,          0, 3'd0, 0, 0, 0, 32'h0);
        tbl[16] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd7, 0, 0, 0, 32'h0);
        tbl[17] = mk(1, 3'd4, 32'h60,        1, 3'd4, 0, 32'h60,          0, 3'd0, 0, 0, 0, 32'h0);
        tbl[18] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd4, 0, 0, 0, 32'h0);
        tbl[19] = mk(0, 3'd0, 32'h0,         1, 3'd4, 1, 32'h64,          0, 3'd0, 0, 0, 0, 32'h0);
        tbl[20] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           1, 3'd4, 1, 0, 0, 32'h0);
        tbl[21] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 1, 1, 32'h64);
        tbl[22] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 1, 32'h0);
        tbl[23] = mk(0, 3'd0, 32'h0,         0, 3'd0, 0, 32'h0,           0, 3'd0, 0, 0, 0, 32'h0);

        // Reset state, with a commit request present.
        m_reset();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 3'd0);
        #12;
        chk("rst_ok", 32'(bus.commit_branch_ok), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flush", 32'(bus.move_flush), 32'd0);
        chk("rst_flush_pc", bus.flush_pc, 32'd0);
        chk("rst_br", bus.br_count, 32'd0);
        chk("rst_mp", bus.mispred_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].av, tbl[i].ar, tbl[i].ap, tbl[i].cv, tbl[i].cr, tbl[i].ct,
                  tbl[i].cp, tbl[i].mv, tbl[i].mr);
            settle_check();
            chk($sformatf("tbl%0d_ok", i), 32'(bus.commit_branch_ok), 32'(tbl[i].exp_ok));
            chk($sformatf("tbl%0d_flush", i), 32'(bus.move_flush), 32'(tbl[i].exp_flush));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
            if (tbl[i].exp_flush) chk($sformatf("tbl%0d_fpc", i), bus.flush_pc, tbl[i].exp_fpc);
            $display("vec %0d: ok=%0b flush=%0b busy=%0b fpc=%08h", i,
                     bus.commit_branch_ok, bus.move_flush, bus.busy, bus.flush_pc);
            tick();
        end
        chk("tbl_br_count", bus.br_count, 32'd4);
        chk("tbl_mispred_count", bus.mispred_count, 32'd2);

        // Asynchronous reset in the middle of a FLUSH cycle.
        drive(1'b1, 3'd0, 32'h100, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 3'd0); step();
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b1, 32'h200, 1'b0, 3'd0); step();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b1, 3'd0); step();
        drive_idle();
        settle_check();
        chk("mid_flush_pulse", 32'(bus.move_flush), 32'd1);
        #1;
        rst = 1'b0;
        bus.commit_valid = 1'b1;
        #1;
        chk("arst_flush", 32'(bus.move_flush), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_br", bus.br_count, 32'd0);
        chk("arst_mp", bus.mispred_count, 32'd0);
        chk("arst_ok", 32'(bus.commit_branch_ok), 32'd0);
        $display("async reset mid-flush: flush=%0b busy=%0b", bus.move_flush, bus.busy);
        m_reset();
        @(posedge clk);
        #1;
        chk("arst_ok_held", 32'(bus.commit_branch_ok), 32'd0);
        rst = 1'b1;
        drive_idle();

        // Tag wrap: allocate 6,7,0,1, resolve out of order, commit in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(6 + i), 32'h300 + 32'(4 * ((6 + i) % 8)), 1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 3'd0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 32'd0, 1'b1, 3'(1 - i), 1'b1, 32'h300 + 32'(4 * ((9 - i) % 8)), 1'b0, 3'd0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 3'(6 + i));
            #1;
            chk($sformatf("wrap_ok%0d", i), 32'(bus.commit_branch_ok), 32'd1);
            $display("wrap commit tag %0d: ok=%0b", (6 + i) % 8, bus.commit_branch_ok);
            #0;
            settle_check();
            tick();
        end
        drive_idle();
        #1;
        chk("wrap_br_count", bus.br_count, 32'd4);
        chk("wrap_mp_count", bus.mispred_count, 32'd0);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'h1000 + 32'(4 * $urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  32'h1000 + 32'(4 * $urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            step();
        end
        $display("random phase: br_count=%0d mispred_count=%0d", bus.br_count, bus.mispred_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
